alu_writeback: RTL and testbench

Result-retirement stage directly downstream of the 3-stage ALU pipeline. Tracks each issued operation through the ALU's fixed 3-cycle latency, pairs the emerging 64-bit result with its destination tag, and retires it. MUL/DIV results go to the HI/LO registers; all other results go to a register-file write port through an in-order buffer. The ALU cannot stall, so issue is credit-gated to guarantee the buffer never overflows.

---
 rtl/alu_wb_pkg.sv | 44 ++++
 rtl/wb_fifo.sv | 69 ++++++
 rtl/alu_writeback.sv | 147 ++++++++++++++
 tb/tb_alu_writeback.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_wb_pkg.sv
// ---------------------------------------------------------------------------
// alu_wb_pkg
// Shared definitions for the ALU result-retirement stage: ALU opcode
// constants, the fixed ALU latency, and the tag carried alongside each op
// while its result is being computed.
// ---------------------------------------------------------------------------
package alu_wb_pkg;

   // Result emerges on c_reg this many cycles after the issue cycle.
   localparam int ALU_LATENCY = 3;

   // Widest destination index the tag can carry; wider DST_W is not supported.
   localparam int DST_MAX_W = 8;

   localparam logic [4:0] OP_NOP  = 5'b00000;
   localparam logic [4:0] OP_ADD  = 5'b00001;
   localparam logic [4:0] OP_ADDU = 5'b00010;
   localparam logic [4:0] OP_SUB  = 5'b00011;
   localparam logic [4:0] OP_SUBU = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_XOR  = 5'b00111;
   localparam logic [4:0] OP_NOR  = 5'b01000;
   localparam logic [4:0] OP_SLT  = 5'b01001;
   localparam logic [4:0] OP_SLTU = 5'b01010;
   localparam logic [4:0] OP_SHL  = 5'b01011;
   localparam logic [4:0] OP_SHR  = 5'b01100;
   localparam logic [4:0] OP_SHRA = 5'b01101;
   localparam logic [4:0] OP_DIV  = 5'b01111;
   localparam logic [4:0] OP_MUL  = 5'b10000;

   typedef struct packed {
      logic                 valid;
      logic [4:0]           opcode;
      logic [DST_MAX_W-1:0] dst;
      logic                 wen;
   } tag_t;

   // MUL/DIV produce a 64-bit result that lands in HI/LO.
   function automatic logic is_hilo_op(logic [4:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
// In-order synchronous FIFO holding retired results waiting for the
// register-file write port. Simultaneous push and pop keep the count.
// Overflow/underflow protection is the caller's job (credit gating).
//
// Ports:
//   clk, clear_i         clock, synchronous active-high clear
//   push_i, wdata_i      write an entry at the tail
//   pop_i                drop the head entry
//   rdata_o              head entry (zero while empty)
//   count_o              number of entries held
//   empty_o, full_o      status flags
// ---------------------------------------------------------------------------
module wb_fifo #(
   parameter int WIDTH = 36,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             clear_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic [CW-1:0]    count_o,
   output logic             empty_o,
   output logic             full_o
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (push_i) wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1);
      if (pop_i)  rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1);
      if (push_i && !pop_i)      cnt_d = cnt_q + CW'(1);
      else if (pop_i && !push_i) cnt_d = cnt_q - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (clear_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage needs no reset: the head is masked while empty.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_q] <= wdata_i;
   end

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign count_o = cnt_q;
   assign rdata_o = empty_o ? '0 : mem_q[rd_q];

endmodule

// File: rtl/alu_writeback.sv
// ---------------------------------------------------------------------------
// alu_writeback
// Retirement stage behind the fixed-latency ALU. A tag pipe follows each
// issued op for ALU_LATENCY cycles so the tag leaving it lines up with
// c_reg. MUL/DIV results update HI/LO; other ops with wen=1 are queued for
// the register-file port; wen=0 ops are dropped. Issue is credit-gated:
// every op holds a credit from issue until it leaves the FIFO (or retires
// without a push), so the FIFO can never overflow even though the ALU
// cannot stall.
//
// Build option: ALU_WB_HILO_EN -- when defined, HI/LO registers exist and
// MUL/DIV retire into them. When undefined, hi_out/lo_out read 0 and
// MUL/DIV are queued like any other op.
//
// Ports:
//   clk, clear              clock, synchronous active-high clear
//   issue_valid/ready       issue handshake; ready = credit available
//   issue_opcode/dst/wen    fields of the op being issued
//   alu_opcode              opcode to the ALU (NOP when not firing)
//   c_reg                   64-bit ALU result, ALU_LATENCY after issue
//   wb_valid/ready          register-file write handshake
//   wb_dst, wb_data         head entry of the result queue
//   hi_out, lo_out          HI/LO registers
//   busy                    any op in flight or queued
// ---------------------------------------------------------------------------
module alu_writeback
   import alu_wb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int DST_W = 4
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             issue_valid,
   output logic             issue_ready,
   input  logic [4:0]       issue_opcode,
   input  logic [DST_W-1:0] issue_dst,
   input  logic             issue_wen,
   output logic [4:0]       alu_opcode,
   input  logic [63:0]      c_reg,
   output logic             wb_valid,
   input  logic             wb_ready,
   output logic [DST_W-1:0] wb_dst,
   output logic [31:0]      wb_data,
   output logic [31:0]      hi_out,
   output logic [31:0]      lo_out,
   output logic             busy
);
   localparam int CW = $clog2(DEPTH + 1);
   // Headroom so tags-in-flight plus FIFO count cannot wrap.
   localparam int UW = CW + 2;
   localparam int FW = DST_W + 32;

   tag_t [ALU_LATENCY-1:0] tag_q, tag_d;
   tag_t                   exit_tag;
   logic                   fire, hilo_hit, push, pop;
   logic [CW-1:0]          fifo_cnt;
   logic                   fifo_empty, fifo_full;
   logic [FW-1:0]          fifo_wdata, fifo_rdata;
   logic [UW-1:0]          used;
   logic                   unused_ok;

   // ---------------- issue / credits ----------------
   always_comb begin
      used = UW'(fifo_cnt);
      for (int i = 0; i < ALU_LATENCY; i++) used = used + UW'(tag_q[i].valid);
   end

   // Depends on registered state only, never on issue_valid or wb_ready.
   assign issue_ready = (used < UW'(DEPTH));
   assign busy        = (used != '0);
   assign fire        = issue_valid & issue_ready;
   assign alu_opcode  = fire ? issue_opcode : OP_NOP;

   // ---------------- tag pipe ----------------
   always_comb begin
      tag_d = '0;
      if (fire) begin
         tag_d[0].valid             = 1'b1;
         tag_d[0].opcode            = issue_opcode;
         tag_d[0].dst[DST_W-1:0]    = issue_dst;
         tag_d[0].wen               = issue_wen;
      end
      for (int i = 1; i < ALU_LATENCY; i++) tag_d[i] = tag_q[i-1];
   end

   always_ff @(posedge clk) begin
      if (clear) tag_q <= '0;
      else       tag_q <= tag_d;
   end

   // Tag leaving the pipe belongs to the value currently on c_reg.
   assign exit_tag = tag_q[ALU_LATENCY-1];

   // ---------------- HI/LO ----------------
`ifdef ALU_WB_HILO_EN
   logic [31:0] hi_q, lo_q;

   assign hilo_hit = exit_tag.valid & is_hilo_op(exit_tag.opcode);

   always_ff @(posedge clk) begin
      if (clear) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (hilo_hit) begin
         hi_q <= c_reg[63:32];
         lo_q <= c_reg[31:0];
      end
   end

   assign hi_out = hi_q;
   assign lo_out = lo_q;
`else
   assign hilo_hit = 1'b0;
   assign hi_out   = '0;
   assign lo_out   = '0;
`endif

   // Upper result half and some tag bits only matter in some builds.
   assign unused_ok = ^{c_reg[63:32], exit_tag};

   // ---------------- result queue ----------------
   assign push       = exit_tag.valid & exit_tag.wen & ~hilo_hit;
   assign pop        = wb_valid & wb_ready;
   assign fifo_wdata = {exit_tag.dst[DST_W-1:0], c_reg[31:0]};

   wb_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk     (clk),
      .clear_i (clear),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (fifo_wdata),
      .rdata_o (fifo_rdata),
      .count_o (fifo_cnt),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   assign wb_valid = ~fifo_empty;
   assign wb_dst   = fifo_rdata[FW-1:32];
   assign wb_data  = fifo_rdata[31:0];

endmodule

// File: tb/tb_alu_writeback.sv
// ---------------------------------------------------------------------------
// tb_alu_writeback
// Directed scenarios followed by random traffic. The bench plays the ALU
// (result on c_reg three cycles after a fire) and keeps a queue-based model
// of ops in flight, queued results and HI/LO, checking every DUT output
// each cycle.
// ---------------------------------------------------------------------------
module tb_alu_writeback;
   localparam int DEPTH = 4;
   localparam int DST_W = 4;
`ifdef ALU_WB_HILO_EN
   localparam bit HILO = 1'b1;
`else
   localparam bit HILO = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             clear, issue_valid, issue_ready, issue_wen;
   logic [4:0]       issue_opcode, alu_opcode;
   logic [DST_W-1:0] issue_dst, wb_dst;
   logic [63:0]      c_reg;
   logic             wb_valid, wb_ready, busy;
   logic [31:0]      wb_data, hi_out, lo_out;

   alu_writeback #(.DEPTH(DEPTH), .DST_W(DST_W)) dut (
      .clk          (clk),
      .clear        (clear),
      .issue_valid  (issue_valid),
      .issue_ready  (issue_ready),
      .issue_opcode (issue_opcode),
      .issue_dst    (issue_dst),
      .issue_wen    (issue_wen),
      .alu_opcode   (alu_opcode),
      .c_reg        (c_reg),
      .wb_valid     (wb_valid),
      .wb_ready     (wb_ready),
      .wb_dst       (wb_dst),
      .wb_data      (wb_data),
      .hi_out       (hi_out),
      .lo_out       (lo_out),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]       opc;
      logic [DST_W-1:0] dst;
      logic             wen;
      logic [63:0]      res;
      int               due;
   } op_t;
   typedef struct {
      logic [DST_W-1:0] dst;
      logic [31:0]      data;
   } wb_t;

   op_t         infl[$];
   wb_t         fq[$];
   logic [31:0] m_hi, m_lo;
   int          cyc;
   int          n_chk, n_err;
   logic        force_en;
   logic [63:0] force_val;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic bit known_op(logic [4:0] op);
      return (op >= 5'd1 && op <= 5'd13) || op == 5'd15 || op == 5'd16;
   endfunction

   // One clock cycle: present the ALU result, check outputs, advance model.
   task automatic tick();
      bit          fire_e, rdy_e;
      op_t         o;
      wb_t         w;
      logic [63:0] r;
      if (infl.size() > 0 && infl[0].due == cyc) c_reg = infl[0].res;
      else c_reg = {$urandom, $urandom};
      @(negedge clk);
      rdy_e  = (infl.size() + fq.size()) < DEPTH;
      fire_e = issue_valid && rdy_e;
      chk("issue_ready", 64'(issue_ready), 64'(rdy_e));
      chk("alu_opcode", 64'(alu_opcode), fire_e ? 64'(issue_opcode) : 64'd0);
      chk("wb_valid", 64'(wb_valid), 64'(fq.size() > 0));
      chk("wb_dst", 64'(wb_dst), fq.size() > 0 ? 64'(fq[0].dst) : 64'd0);
      chk("wb_data", 64'(wb_data), fq.size() > 0 ? 64'(fq[0].data) : 64'd0);
      chk("hi_out", 64'(hi_out), 64'(m_hi));
      chk("lo_out", 64'(lo_out), 64'(m_lo));
      chk("busy", 64'(busy), 64'((infl.size() + fq.size()) > 0));
      chk("fifo_overflow", 64'(dut.u_fifo.push_i & dut.u_fifo.full_o), 64'd0);
      chk("fifo_underflow", 64'(dut.u_fifo.pop_i & dut.u_fifo.empty_o), 64'd0);
      @(posedge clk);
      if (clear) begin
         infl.delete();
         fq.delete();
         m_hi = '0;
         m_lo = '0;
      end else begin
         if (wb_ready && fq.size() > 0) void'(fq.pop_front());
         if (infl.size() > 0 && infl[0].due == cyc) begin
            o = infl.pop_front();
            if (HILO && (o.opc == 5'd16 || o.opc == 5'd15)) begin
               m_hi = o.res[63:32];
               m_lo = o.res[31:0];
            end else if (o.wen) begin
               w.dst  = o.dst;
               w.data = o.res[31:0];
               fq.push_back(w);
            end
         end
         if (fire_e) begin
            r = force_en ? force_val : (known_op(issue_opcode) ? {$urandom, $urandom} : 64'd0);
            o.opc = issue_opcode;
            o.dst = issue_dst;
            o.wen = issue_wen;
            o.res = r;
            o.due = cyc + 3;
            infl.push_back(o);
         end
      end
      cyc++;
      #1;
   endtask

   task automatic set_issue(input logic v, input logic [4:0] op, input logic [DST_W-1:0] d,
                            input logic wen);
      issue_valid  = v;
      issue_opcode = op;
      issue_dst    = d;
      issue_wen    = wen;
   endtask

   initial begin
      int nf;
      n_chk = 0; n_err = 0; cyc = 0;
      force_en = 1'b0; force_val = '0;
      m_hi = '0; m_lo = '0;
      clear = 1'b1; wb_ready = 1'b0; c_reg = '0;
      set_issue(1'b0, 5'd0, '0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_issue_ready", 64'(issue_ready), 64'd1);
      chk("rst_alu_opcode", 64'(alu_opcode), 64'd0);
      chk("rst_wb_valid", 64'(wb_valid), 64'd0);
      chk("rst_wb_dst", 64'(wb_dst), 64'd0);
      chk("rst_wb_data", 64'(wb_data), 64'd0);
      chk("rst_hi", 64'(hi_out), 64'd0);
      chk("rst_lo", 64'(lo_out), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      clear = 1'b0;

      // Single ADD, dst=5, result 7.
      force_en = 1'b1; force_val = 64'h7;
      set_issue(1'b1, 5'd1, 4'd5, 1'b1);
      tick();
      set_issue(1'b0, 5'd0, '0, 1'b0);
      repeat (2) tick();
      chk("add_no_early_valid", 64'(wb_valid), 64'd0);
      tick();
      chk("add_wb_valid", 64'(wb_valid), 64'd1);
      chk("add_wb_dst", 64'(wb_dst), 64'd5);
      chk("add_wb_data", 64'(wb_data), 64'h7);
      repeat (2) tick();
      chk("add_stall_data", 64'(wb_data), 64'h7);
      wb_ready = 1'b1;
      tick();
      chk("add_busy_after_pop", 64'(busy), 64'd0);

      // MUL into HI/LO (or queued when HI/LO is not built).
      wb_ready = 1'b0;
      force_val = 64'h0000_0001_8000_0000;
      set_issue(1'b1, 5'd16, 4'd3, 1'b1);
      tick();
      set_issue(1'b0, 5'd0, '0, 1'b0);
      repeat (3) tick();
      if (HILO) begin
         chk("mul_hi", 64'(hi_out), 64'h1);
         chk("mul_lo", 64'(lo_out), 64'h8000_0000);
         chk("mul_no_wb", 64'(wb_valid), 64'd0);
      end else begin
         chk("mul_wb_valid", 64'(wb_valid), 64'd1);
         chk("mul_wb_data", 64'(wb_data), 64'h8000_0000);
      end
      wb_ready = 1'b1;
      tick();
      force_en = 1'b0;

      // Credit exhaustion with the write port stalled.
      wb_ready = 1'b0;
      nf = 0;
      for (int i = 0; i < 8; i++) begin
         set_issue(1'b1, 5'(1 + (i % 13)), 4'(i + 8), 1'b1);
         if (issue_ready) nf++;
         tick();
      end
      chk("credit_fires", 64'(nf), 64'd4);
      chk("credit_ready_low", 64'(issue_ready), 64'd0);
      wb_ready = 1'b1;
      tick();
      chk("credit_resume", 64'(issue_ready), 64'd1);
      set_issue(1'b0, 5'd0, '0, 1'b0);
      repeat (8) tick();

      // wen=0 op: no push, credit freed when it leaves the pipe.
      set_issue(1'b1, 5'd2, 4'd9, 1'b0);
      tick();
      set_issue(1'b0, 5'd0, '0, 1'b0);
      repeat (3) tick();
      chk("nowen_busy", 64'(busy), 64'd0);
      chk("nowen_wb_valid", 64'(wb_valid), 64'd0);

      // clear with one buffered and two in flight.
      wb_ready = 1'b0;
      set_issue(1'b1, 5'd3, 4'd1, 1'b1); tick();
      set_issue(1'b0, 5'd0, '0, 1'b0);   tick();
      set_issue(1'b1, 5'd4, 4'd2, 1'b1); tick();
      set_issue(1'b1, 5'd5, 4'd3, 1'b1); tick();
      set_issue(1'b0, 5'd0, '0, 1'b0);
      chk("pre_clear_wb_valid", 64'(wb_valid), 64'd1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr_wb_valid", 64'(wb_valid), 64'd0);
      chk("clr_busy", 64'(busy), 64'd0);
      chk("clr_hi", 64'(hi_out), 64'd0);
      chk("clr_lo", 64'(lo_out), 64'd0);
      chk("clr_issue_ready", 64'(issue_ready), 64'd1);
      repeat (6) tick();
      chk("clr_no_stale", 64'(wb_valid), 64'd0);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         set_issue(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
                   4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
         wb_ready = 1'($urandom_range(0, 2) != 0);
         clear    = 1'($urandom_range(0, 99) == 0);
         tick();
      end
      clear = 1'b0;
      set_issue(1'b0, 5'd0, '0, 1'b0);
      wb_ready = 1'b1;
      repeat (10) tick();
      chk("final_idle", 64'(busy), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
